// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Brief    : Segment patterns (GFEDCBA, active-low) and slot FSM state type.
// Revision : 1.0
// ============================================================================
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seven_seg_mux_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_mux_driver_if
// Brief    : Digit data inputs and segment/anode outputs of the mux driver.
// Revision : 1.0
// ============================================================================
interface seven_seg_mux_driver_if #(
    parameter int NUM_DIGITS = 2
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] hex_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    hex_mode;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;

    modport master (
        output hex_in, digit_en, hex_mode,
        input  seg, an, digit_idx
    );

    modport slave (
        input  hex_in, digit_en, hex_mode,
        output seg, an, digit_idx
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_decoder
// Brief    : Nibble to active-low GFEDCBA pattern; decimal mode blanks 10-15.
// Revision : 1.0
// ============================================================================
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  wire [3:0] value,
    input  wire       hex_mode,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (value)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            default: seg = SEG_F;
        endcase
        if (!hex_mode && (value > 4'd9)) begin
            seg = SEG_OFF;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_mux_driver
// Brief    : Time-multiplexed seven-segment driver with per-slot dead time.
// Revision : 1.0
// ============================================================================
module seven_seg_mux_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DIV_W        = 12,
    parameter int BLANK_CYCLES = 16
) (
    input wire clk,
    input wire reset,
    seven_seg_mux_driver_if.slave bus
);

    localparam int              IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] CNT_MAX   = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      cnt;
    logic [DIV_W-1:0]      cnt_nxt;
    logic                  wrap;
    logic [IDX_W-1:0]      idx;
    state_t                state;
    state_t                state_nxt;
    logic [3:0]            nib_sel;
    logic                  en_sel;
    logic [3:0]            sh_nib;
    logic                  sh_en;
    logic                  sh_mode;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_d;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_d;
    logic [NUM_DIGITS-1:0] an_q;

    assign cnt_nxt = cnt + DIV_W'(1);
    assign wrap    = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BLANK: if (!wrap && (cnt_nxt >= BLANK_END)) state_nxt = ST_ON;
            ST_ON:    if (wrap) state_nxt = ST_BLANK;
            default:  state_nxt = ST_BLANK;
        endcase
    end

    always_comb begin
        nib_sel = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nib_sel = bus.hex_in[4*k +: 4];
            end
        end
        en_sel = bus.digit_en[idx];
    end

    // Capture happens during the first BLANK cycle of every slot, which also
    // covers the very first slot after reset when no wrap has occurred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_nib  <= '0;
            sh_en   <= 1'b0;
            sh_mode <= 1'b0;
        end else if (cnt == '0) begin
            sh_nib  <= nib_sel;
            sh_en   <= en_sel;
            sh_mode <= bus.hex_mode;
        end
    end

    seven_seg_decoder u_decoder (
        .value    (sh_nib),
        .hex_mode (sh_mode),
        .seg      (dec_seg)
    );

    // Lighting requires ON to persist into the next cycle, so the registered
    // outputs are already dark on the first cycle of the following slot.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '1;
        if ((state == ST_ON) && (state_nxt == ST_ON) && sh_en) begin
            seg_d     = dec_seg;
            an_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q <= SEG_OFF;
            an_q  <= '1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.digit_idx = idx;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_mux_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_mux_driver
// Brief    : Vector table, corner sequences and random run against a slot model.
// Revision : 1.0
// ============================================================================
module tb_seven_seg_mux_driver;

    localparam int ND    = 2;
    localparam int DW    = 4;
    localparam int BLK   = 2;
    localparam int SLOT  = 1 << DW;
    localparam logic [6:0] OFF = 7'b1111111;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seven_seg_mux_driver_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_mux_driver #(
        .NUM_DIGITS   (ND),
        .DIV_W        (DW),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] hex;
        logic [1:0] en;
        logic       mode;
        logic [1:0] an0;
        logic [6:0] seg0;
        logic [1:0] an1;
        logic [6:0] seg1;
    } vec_t;

    vec_t       vecs [6];
    int         cyc_list [10];
    logic [6:0] ref_tbl [16];

    int n_assert = 0;
    int n_fail   = 0;
    int t        = 0;

    logic [7:0] cap_hex;
    logic [1:0] cap_en;
    logic       cap_mode;

    function automatic logic [6:0] ref_dec(input logic [3:0] nib, input logic mode);
        if (!mode && nib > 4'd9) return OFF;
        return ref_tbl[nib];
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, t, got, exp);
        end
    endtask

    // Advance to cycle c (sampled 1 time unit after the falling edge); the
    // model keeps whatever inputs were present during each slot's cycle 0.
    task automatic goto_cycle(input int c);
        while (t < c) begin
            if (t % SLOT == 0) begin
                cap_hex  = bus.hex_in;
                cap_en   = bus.digit_en;
                cap_mode = bus.hex_mode;
            end
            @(negedge clk);
            t++;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_an",  16'(bus.an), 16'(2'b11));
        chk("rst_seg", 16'(bus.seg), 16'(OFF));
        chk("rst_idx", 16'(bus.digit_idx), 16'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t = 0;
    endtask

    task automatic check_model();
        int         cyc;
        int         d;
        logic [1:0] e_an;
        logic [6:0] e_seg;
        cyc   = t % SLOT;
        d     = (t / SLOT) % ND;
        e_an  = 2'b11;
        e_seg = OFF;
        if (cyc >= BLK + 1 && cap_en[d]) begin
            e_an[d] = 1'b0;
            e_seg   = ref_dec(cap_hex[4*d +: 4], cap_mode);
        end
        chk("mdl_an",  16'(bus.an), 16'(e_an));
        chk("mdl_seg", 16'(bus.seg), 16'(e_seg));
        chk("mdl_idx", 16'(bus.digit_idx), 16'(d));
        chk("mdl_onehot", 16'($countones(~bus.an) <= 1), 16'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ref_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        vecs[0] = '{8'h31, 2'b11, 1'b1, 2'b10, 7'b1111001, 2'b01, 7'b0110000};
        vecs[1] = '{8'hFA, 2'b11, 1'b1, 2'b10, 7'b0001000, 2'b01, 7'b0001110};
        vecs[2] = '{8'hFA, 2'b11, 1'b0, 2'b10, OFF,        2'b01, OFF};
        vecs[3] = '{8'h31, 2'b10, 1'b1, 2'b11, OFF,        2'b01, 7'b0110000};
        vecs[4] = '{8'h0B, 2'b01, 1'b1, 2'b10, 7'b0000011, 2'b11, OFF};
        vecs[5] = '{8'h5C, 2'b11, 1'b0, 2'b10, OFF,        2'b01, 7'b0010010};
        cyc_list = '{1, 2, 3, 8, 15, 16, 19, 24, 31, 32};

        reset        = 1'b1;
        bus.hex_in   = 8'h00;
        bus.digit_en = 2'b00;
        bus.hex_mode = 1'b0;

        // Table-driven vectors over two full slots
        for (int v = 0; v < 6; v++) begin
            bus.hex_in   = vecs[v].hex;
            bus.digit_en = vecs[v].en;
            bus.hex_mode = vecs[v].mode;
            do_reset();
            for (int i = 0; i < 10; i++) begin
                int         cyc;
                int         d;
                logic [1:0] e_an;
                logic [6:0] e_seg;
                goto_cycle(cyc_list[i]);
                cyc   = t % SLOT;
                d     = (t / SLOT) % ND;
                e_an  = 2'b11;
                e_seg = OFF;
                if (cyc >= BLK + 1) begin
                    e_an  = (d == 0) ? vecs[v].an0  : vecs[v].an1;
                    e_seg = (d == 0) ? vecs[v].seg0 : vecs[v].seg1;
                end
                chk($sformatf("vec%0d_an", v),  16'(bus.an), 16'(e_an));
                chk($sformatf("vec%0d_seg", v), 16'(bus.seg), 16'(e_seg));
                chk($sformatf("vec%0d_idx", v), 16'(bus.digit_idx), 16'(d));
            end
        end

        // Mid-slot input change must not disturb the current slot
        bus.hex_in   = 8'h05;
        bus.digit_en = 2'b11;
        bus.hex_mode = 1'b1;
        do_reset();
        goto_cycle(8);
        bus.hex_in = 8'h09;
        goto_cycle(10);
        chk("hold_seg_c10", 16'(bus.seg), 16'(7'b0010010));
        chk("hold_an_c10",  16'(bus.an), 16'(2'b10));
        goto_cycle(15);
        chk("hold_seg_c15", 16'(bus.seg), 16'(7'b0010010));
        goto_cycle(19);
        chk("hold_d1_seg",  16'(bus.seg), 16'(7'b1000000));
        chk("hold_d1_an",   16'(bus.an), 16'(2'b01));
        goto_cycle(35);
        chk("new_seg_c35",  16'(bus.seg), 16'(7'b0010000));
        chk("new_an_c35",   16'(bus.an), 16'(2'b10));

        // Asynchronous reset in the middle of the digit-1 slot
        bus.hex_in   = 8'h31;
        bus.digit_en = 2'b11;
        bus.hex_mode = 1'b1;
        do_reset();
        goto_cycle(26);
        chk("pre_rst_an", 16'(bus.an), 16'(2'b01));
        reset = 1'b1;
        #1;
        chk("async_an",  16'(bus.an), 16'(2'b11));
        chk("async_seg", 16'(bus.seg), 16'(OFF));
        chk("async_idx", 16'(bus.digit_idx), 16'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        t = 0;
        goto_cycle(1);
        chk("rr_an_c1",  16'(bus.an), 16'(2'b11));
        chk("rr_seg_c1", 16'(bus.seg), 16'(OFF));
        goto_cycle(3);
        chk("rr_an_c3",  16'(bus.an), 16'(2'b10));
        chk("rr_seg_c3", 16'(bus.seg), 16'(7'b1111001));
        goto_cycle(16);
        chk("rr_an_c16", 16'(bus.an), 16'(2'b11));
        goto_cycle(19);
        chk("rr_seg_c19", 16'(bus.seg), 16'(7'b0110000));

        // Random inputs over 1000 slots against the slot model
        do_reset();
        for (int i = 0; i < SLOT * 1000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.hex_in   = 8'($urandom);
                bus.digit_en = 2'($urandom);
                bus.hex_mode = 1'($urandom);
            end
            goto_cycle(t + 1);
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_mux_driver.md
SEVEN_SEG_MUX_DRIVER -- requirements
Module: seven_seg_mux_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 2, number of multiplexed digits; SHALL be legal over 2..8.
REQ-002 Parameter DIV_W, default 12, slot counter width; slot length = 2^DIV_W clk cycles; SHALL be legal over 3..20.
REQ-003 Parameter BLANK_CYCLES, default 16, dead-time cycles at slot start; SHALL satisfy 1 <= BLANK_CYCLES < 2^DIV_W.
REQ-004 clk  input  1  single clock; all state SHALL be on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 hex_in  input  4*NUM_DIGITS  nibble k (bits 4k+3:4k) is the value for digit k.
REQ-007 digit_en  input  NUM_DIGITS  bit k=1 allows digit k to light; 0 blanks it.
REQ-008 hex_mode  input  1  1 = decode 0-F; 0 = decode 0-9 only, 10-15 blank.
REQ-009 seg  output  7  active-low segments, bit order GFEDCBA (bit 6 = G, bit 0 = A).
REQ-010 an  output  NUM_DIGITS  active-low digit enables, one-hot-low or all-high.
REQ-011 digit_idx  output  $clog2(NUM_DIGITS)  index of digit owning the current slot.

Function
REQ-012 Slot counter SHALL count 0..2^DIV_W-1 and wrap; digit_idx SHALL increment at wrap, going NUM_DIGITS-1 -> 0.
REQ-013 FSM states BLANK and ON: BLANK while counter < BLANK_CYCLES, ON otherwise; BLANK SHALL be entered on every counter wrap.
REQ-014 In BLANK, an SHALL be all ones and seg SHALL be 7'b1111111.
REQ-015 On BLANK entry, hex_in nibble, digit_en bit and hex_mode for the new digit_idx SHALL be captured into a shadow register; input changes mid-slot SHALL NOT affect the slot.
REQ-016 In ON, an[digit_idx] SHALL be 0 iff captured enable = 1, other bits 1; seg SHALL be the decode of the captured nibble, or all ones if captured enable = 0.
REQ-017 Decode (GFEDCBA): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110.
REQ-018 With hex_mode=0, nibbles 10-15 SHALL decode to 1111111.
REQ-019 seg and an SHALL be registered outputs; they change only at clk edges and stay glitch-free, with 1-cycle latency from counter/state to outputs.
REQ-020 an and seg SHALL never both select a digit while any other an bit is 0; at most one an bit SHALL be 0 in any cycle.

Reset
REQ-021 While reset=1: counter=0, digit_idx=0, FSM=BLANK, shadow cleared, seg=7'b1111111, an all ones.
REQ-022 Reset asserted mid-slot SHALL force the reset values immediately (asynchronously); after release the first slot SHALL be digit 0 starting in BLANK.

Structure
REQ-023 Package seven_seg_pkg SHALL hold the 16 segment-pattern constants, SEG_OFF = 7'b1111111, and the FSM state enum.
REQ-024 Decode SHALL be one combinational sub-module seven_seg_decoder (in: 4-bit value, hex_mode; out: 7-bit seg), instantiated once on the shadow nibble.
REQ-025 Target size 120-400 RTL lines; no inferred latches; no other sub-modules.

Verification (NUM_DIGITS=2, DIV_W=4, BLANK_CYCLES=2, slot=16 cycles)
REQ-026 Reset release, hex_in=8'h31, digit_en=2'b11, hex_mode=1 -> cycles 0-1 an=11 seg=1111111; from the edge after cycle 2, an=10 seg=1111001 through cycle 15; next slot an=01 seg=0110000.
REQ-027 hex_in=8'hFA, hex_mode=1 -> digit0 seg=0001000, digit1 seg=0001110; repeat with hex_mode=0 -> both 1111111, an still pulsing.
REQ-028 digit_en=2'b10 -> digit0 slot an=11 seg=1111111 throughout; digit1 slot normal.
REQ-029 Change hex_in[3:0] 5->9 at cycle 8 of digit0 slot -> seg stays 0010010 until slot end; next digit0 slot shows 0010000.
REQ-030 Assert reset at cycle 10 of digit1 slot -> same cycle an=11 seg=1111111 digit_idx=0; after release sequence restarts as REQ-026.
REQ-031 Continuous assertion over 1000 slots -> at most one an bit low per cycle, digit_idx order 0,1,0,1..., an=all-ones on the cycle(s) spanning each slot boundary.
